ldo_rr_arbiter: RTL and testbench
=================================

// Module: ldo_rr_arbiter
// PURPOSE
//  32-requester round-robin arbiter for one shared resource (bus port, ALU slot, etc.).
//  Arbitration picks the highest-index requester with a leading-one finder, operating on
//  either a rotation-masked or a full request vector.
//  A grant is held until the resource releases it, the requester drops its request, or a
//  hold timeout expires. Sits between 32 request sources and one resource controller.
// PARAMETERS
//  RR_EN     1   1 = round-robin (mask by last grant); 0 = fixed priority (index 31 highest)
//  MAX_HOLD  16  max cycles a grant may be held before forced revoke; 0 = no timeout
//  CNT_W     8   hold-counter width; MAX_HOLD must be < 2**CNT_W
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   synchronous reset, active-low
//  req        in   32  level request per source, bit i = source i
//  rel        in   1   single-cycle release pulse from resource; valid only while gnt_valid=1
//  gnt_valid  out  1   grant active
//  gnt_id     out  5   index of granted source; 0 when gnt_valid=0
//  gnt_vec    out  32  one-hot grant; all zeros when gnt_valid=0
//  expire     out  1   1-cycle pulse: current grant revoked by timeout
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge) -> next cycle: state=IDLE, all outputs 0, hold_cnt=0, mask=32'hFFFF_FFFF.
//  Reset applied during BUSY drops the grant with no expire pulse.
//  FSM states:
//   - IDLE: if req!=0, latch winner; next cycle BUSY with gnt_valid=1 (1-cycle req->grant latency).
//   - BUSY: outputs are registered and stable. Exit to IDLE next cycle on any of:
//     (a) rel=1;
//     (b) req[gnt_id]=0 (abandon);
//     (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> expire=1 in the same cycle gnt_valid falls.
//  No back-to-back grants: there is always >=1 IDLE cycle with gnt_valid=0 between grants.
//  Winner select:
//   - m = req & mask.
//   - If m!=0, winner = 31 - clz(m); else winner = 31 - clz(req).
//   - clz = leading-zero count; clz=32 only when the vector is zero, which is never used
//     for a grant.
//  Mask update on grant of index g:
//   - RR_EN=1: mask = (1<<g)-1, so only indices < g are preferred; g=0 gives mask=0,
//     which falls back to the full vector.
//   - RR_EN=0: mask stays all-ones.
//  hold_cnt: cleared on grant, +1 per BUSY cycle, saturates. Counter width rules: CNT_W bits, unsigned.
//  Simultaneous events:
//   - rel together with timeout -> treated as release, expire=0.
//   - rel together with abandon -> release, expire=0.
//  Ignored inputs: rel while IDLE; changes in req bits other than gnt_id during BUSY
//  (they do not affect the grant).
//  After expire the mask still advances, so under RR_EN=1 the expired source cannot starve
//  the others. Under RR_EN=0 the same source may be re-granted after the IDLE bubble.
// STRUCTURE
//  Shared package ldo_pkg:
//   - localparam NREQ=32, IDX_W=5, POS_W=6;
//   - state encoding ST_IDLE/ST_BUSY;
//   - constant CLZ_ZERO=6'd32.
//  Sub-module: two instances of ldo_find, the existing 32-bit leading-one finder.
//   - Inputs: the masked and the full vector.
//   - Output: 6-bit leading-zero count, 32 when the input is 0.
//   - Index = 31 - pos_out[4:0].
//  Everything else (FSM, mask register, hold counter, one-hot decode) is local to this module.
// TESTING
//  1. req=32'h0000_0001 -> next cycle gnt_valid=1, gnt_id=0, gnt_vec=1; rel pulse -> next cycle all 0.
//  2. RR_EN=1, req held at 32'h8000_0011 with rel after each grant:
//     grants run 31,4,0,31,4,... with one IDLE cycle between grants.
//  3. RR_EN=0, same req -> every grant is 31.
//  4. MAX_HOLD=16, req=32'h0000_0100, no rel -> gnt_valid stays high 16 cycles, then expire=1
//     for 1 cycle and gnt_valid=0.
//  5. Grant id 7 active, drop req[7] -> next cycle gnt_valid=0, expire=0.
//     Then rel and timeout in the same cycle -> expire=0.
//  6. rst_n=0 during BUSY (gnt_id=12) -> next cycle all outputs 0, mask all-ones.
//     After release with req=32'h0000_1001, grant goes to 12.

Source files
------------

// File: rtl/ldo_pkg.sv
// Shared types and constants for the round-robin arbiter and its leading-one finder.
package ldo_pkg;

  localparam int NREQ  = 32;
  localparam int IDX_W = 5;
  localparam int POS_W = 6;

  // Leading-zero count reported for an all-zero vector.
  localparam logic [POS_W-1:0] CLZ_ZERO = 6'd32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/ldo_find.sv
// 32-bit leading-one finder: reports the leading-zero count, or 32 for a zero input.
module ldo_find
  import ldo_pkg::*;
(
  input  logic [NREQ-1:0]  vec,
  output logic [POS_W-1:0] pos_out
);

  // NOTE: the default assignment before the loop keeps this purely combinational;
  // without it any path that skips an assignment would infer a latch.
  always_comb begin
    pos_out = CLZ_ZERO;
    // Scanning upward lets the highest set bit make the final assignment.
    for (int i = 0; i < NREQ; i++) begin
      if (vec[i]) pos_out = POS_W'(NREQ - 1 - i);
    end
  end

endmodule

// File: rtl/ldo_rr_arbiter.sv
// 32-requester round-robin / fixed-priority arbiter with hold timeout and registered
// one-hot grant. Winner is the highest-index requester of the masked (or full) vector.
module ldo_rr_arbiter
  import ldo_pkg::*;
#(
  parameter bit RR_EN    = 1'b1,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic              rel,
  output logic              gnt_valid,
  output logic [IDX_W-1:0]  gnt_id,
  output logic [NREQ-1:0]   gnt_vec,
  output logic              expire
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [NREQ-1:0]  mask;
  logic [CNT_W-1:0] hold_cnt;

  logic [NREQ-1:0]  masked_req;
  logic [POS_W-1:0] pos_masked;
  logic [POS_W-1:0] pos_full;
  logic             masked_any;
  logic             req_any;
  logic [IDX_W-1:0] winner;
  logic             abandon;
  logic             timeout;

  assign masked_req = req & mask;

  ldo_find u_find_masked (
    .vec     (masked_req),
    .pos_out (pos_masked)
  );

  ldo_find u_find_full (
    .vec     (req),
    .pos_out (pos_full)
  );

  assign masked_any = (pos_masked != CLZ_ZERO);
  assign req_any    = (pos_full != CLZ_ZERO);

  // An empty masked vector (including mask=0 after granting index 0) falls back to
  // plain priority over the full request vector.
  assign winner = masked_any ? (IDX_W'(NREQ - 1) - pos_masked[IDX_W-1:0])
                             : (IDX_W'(NREQ - 1) - pos_full[IDX_W-1:0]);

  assign abandon = ~req[gnt_id];
  assign timeout = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  // NOTE: every register here is updated with non-blocking assignments so that all
  // reads in this block see the pre-edge values, matching the flops that get built.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      gnt_vec   <= '0;
      expire    <= 1'b0;
      hold_cnt  <= '0;
      mask      <= '1;
    end else begin
      expire <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            state     <= ST_BUSY;
            gnt_valid <= 1'b1;
            gnt_id    <= winner;
            gnt_vec   <= idx_to_onehot(winner);
            hold_cnt  <= '0;
            if (RR_EN) mask <= idx_to_onehot(winner) - NREQ'(1);
          end
        end

        ST_BUSY: begin
          if (rel || abandon || timeout) begin
            state     <= ST_IDLE;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            gnt_vec   <= '0;
            // Release and abandon take precedence: only a pure timeout is flagged.
            expire    <= timeout && !rel && !abandon;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldo_rr_arbiter.sv
// Bench for ldo_rr_arbiter: round-robin and fixed-priority instances driven in lockstep,
// checked every cycle against a scan-based reference model plus directed expectations.
module tb_ldo_rr_arbiter;

  localparam int MAX_HOLD = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] req;
  logic        rel;

  logic        gv   [2];
  logic [4:0]  gi   [2];
  logic [31:0] gvec [2];
  logic        ex   [2];

  int n_checks;
  int n_errors;

  // Reference model state per instance: 0 = round-robin, 1 = fixed priority.
  bit m_busy [2];
  int m_gid  [2];
  int m_hold [2];
  int m_lg   [2];
  bit m_exp  [2];
  bit rr_mode[2];

  ldo_rr_arbiter #(.RR_EN(1'b1), .MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
    .gnt_valid (gv[0]),
    .gnt_id    (gi[0]),
    .gnt_vec   (gvec[0]),
    .expire    (ex[0])
  );

  ldo_rr_arbiter #(.RR_EN(1'b0), .MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rel       (rel),
    .gnt_valid (gv[1]),
    .gnt_id    (gi[1]),
    .gnt_vec   (gvec[1]),
    .expire    (ex[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Highest requester strictly below the last grant, else highest requester overall.
  function automatic int pick(input logic [31:0] r, input int lg);
    for (int i = 31; i >= 0; i--) if (r[i] && i < lg) return i;
    for (int i = 31; i >= 0; i--) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_update(input int k);
    if (!rst_n) begin
      m_busy[k] = 1'b0; m_gid[k] = 0; m_hold[k] = 0; m_lg[k] = 32; m_exp[k] = 1'b0;
    end else if (m_busy[k]) begin
      m_exp[k] = 1'b0;
      if (rel || !req[m_gid[k]]) begin
        m_busy[k] = 1'b0;
      end else if (MAX_HOLD != 0 && m_hold[k] == MAX_HOLD - 1) begin
        m_busy[k] = 1'b0;
        m_exp[k]  = 1'b1;
      end else if (m_hold[k] < 255) begin
        m_hold[k]++;
      end
    end else begin
      m_exp[k] = 1'b0;
      if (req != 32'd0) begin
        m_gid[k]  = pick(req, m_lg[k]);
        m_busy[k] = 1'b1;
        m_hold[k] = 0;
        if (rr_mode[k]) m_lg[k] = m_gid[k];
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      string nm;
      logic [31:0] e_vec;
      nm    = (k == 0) ? "rr" : "fp";
      e_vec = m_busy[k] ? (32'd1 << m_gid[k]) : 32'd0;
      check({nm, ".gnt_valid"}, 32'(gv[k]), 32'(m_busy[k]));
      check({nm, ".gnt_id"}, 32'(gi[k]), m_busy[k] ? 32'(m_gid[k]) : 32'd0);
      check({nm, ".gnt_vec"}, gvec[k], e_vec);
      check({nm, ".expire"}, 32'(ex[k]), 32'(m_exp[k]));
    end
  endtask

  // One clock: model advances on the same edge as the DUTs, outputs compared 1 ns later.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; rel = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (!gv[0] && n < 8) begin
      step();
      n++;
    end
    if (!gv[0]) check({tag, ".grant_timeout"}, 32'(gv[0]), 32'd1);
  endtask

  initial begin
    int cnt;
    int seq_rr[6];
    int seq_fp[6];
    n_checks = 0;
    n_errors = 0;
    rr_mode[0] = 1'b1;
    rr_mode[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; m_gid[k] = 0; m_hold[k] = 0; m_lg[k] = 32; m_exp[k] = 1'b0;
    end

    // Reset state.
    do_reset();
    check("reset.gnt_valid", 32'(gv[0]), 32'd0);
    check("reset.gnt_vec", gvec[0], 32'd0);

    // Single requester 0, then release.
    req = 32'h0000_0001;
    step();
    check("t1.gnt_valid", 32'(gv[0]), 32'd1);
    check("t1.gnt_id", 32'(gi[0]), 32'd0);
    check("t1.gnt_vec", gvec[0], 32'd1);
    req = '0; rel = 1'b1;
    step();
    rel = 1'b0;
    check("t1.rel_valid", 32'(gv[0]), 32'd0);
    check("t1.rel_vec", gvec[0], 32'd0);

    // Rotation versus fixed priority with three requesters.
    do_reset();
    req = 32'h8000_0011;
    for (int g = 0; g < 6; g++) begin
      wait_grant("t2");
      seq_rr[g] = int'(gi[0]);
      seq_fp[g] = int'(gi[1]);
      rel = 1'b1;
      step();
      rel = 1'b0;
      check("t2.idle_gap", 32'(gv[0]), 32'd0);
    end
    for (int g = 0; g < 6; g++) begin
      check($sformatf("t2.rr_seq%0d", g), 32'(seq_rr[g]), (g % 3 == 0) ? 32'd31 : (g % 3 == 1) ? 32'd4 : 32'd0);
      check($sformatf("t3.fp_seq%0d", g), 32'(seq_fp[g]), 32'd31);
    end

    // Hold timeout.
    do_reset();
    req = 32'h0000_0100;
    wait_grant("t4");
    cnt = 0;
    while (gv[0] && cnt < 40) begin
      cnt++;
      step();
    end
    check("t4.hold_cycles", 32'(cnt), 32'd16);
    check("t4.expire", 32'(ex[0]), 32'd1);
    check("t4.valid_low", 32'(gv[0]), 32'd0);
    req = '0;
    step();
    check("t4.expire_pulse", 32'(ex[0]), 32'd0);

    // Abandon, then release coinciding with timeout.
    do_reset();
    req = 32'h0000_0080;
    wait_grant("t5");
    check("t5.gnt_id", 32'(gi[0]), 32'd7);
    req = '0;
    step();
    check("t5.abandon_valid", 32'(gv[0]), 32'd0);
    check("t5.abandon_expire", 32'(ex[0]), 32'd0);
    req = 32'h0000_0080;
    wait_grant("t5b");
    for (int i = 0; i < MAX_HOLD - 1; i++) step();
    check("t5.still_held", 32'(gv[0]), 32'd1);
    rel = 1'b1;
    step();
    rel = 1'b0;
    req = '0;
    check("t5.rel_timeout_valid", 32'(gv[0]), 32'd0);
    check("t5.rel_timeout_expire", 32'(ex[0]), 32'd0);

    // Reset while busy restores the all-ones mask.
    do_reset();
    req = 32'h0000_1000;
    wait_grant("t6");
    check("t6.gnt_id", 32'(gi[0]), 32'd12);
    rst_n = 1'b0;
    step();
    check("t6.reset_valid", 32'(gv[0]), 32'd0);
    check("t6.reset_id", 32'(gi[0]), 32'd0);
    check("t6.reset_expire", 32'(ex[0]), 32'd0);
    rst_n = 1'b1;
    req = 32'h0000_1001;
    wait_grant("t6b");
    check("t6.regrant_id", 32'(gi[0]), 32'd12);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: req = '0;
          1: req = $urandom & $urandom & $urandom;
          2: req = 32'd1 << $urandom_range(0, 31);
          default: req = $urandom;
        endcase
      end
      rel   = ($urandom_range(0, 9) < 2);
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
